// File: rtl/pn_pkg.sv
// Shared types and constants for the physical-neuron soma controller.
// Covers the FSM state encoding, the config-word field layout and the event-word layout.
package pn_pkg;

    typedef enum logic [2:0] {
        StUncfg,
        StLoad,
        StReady,
        StIssue,
        StHold
    } state_e;

    // Config word layout: {V_th, V_leak, refr_time, axon_delay}
    localparam int unsigned CfgW       = 32;
    localparam int unsigned CfgFieldW  = 8;
    localparam int unsigned VthLsb     = 24;
    localparam int unsigned VleakLsb   = 16;
    localparam int unsigned RefrLsb    = 8;
    localparam int unsigned AxonLsb    = 0;

    // Queued event word layout: {interval, weight}
    localparam int unsigned EvIntW     = 16;
    localparam int unsigned EvWeightW  = 16;
    localparam int unsigned EvW        = EvIntW + EvWeightW;

    // The soma takes the event interval zero-extended on its W_DATA bus.
    function automatic logic [CfgW-1:0] ev_wdata(input logic [EvIntW-1:0] interval);
        return {{(CfgW - EvIntW){1'b0}}, interval};
    endfunction

endpackage

// File: rtl/pn_event_fifo.sv
// Synchronous event queue with flush; full/empty/count are all derived from registers.
// Pointers wrap naturally because DEPTH is a power of two.
module pn_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FullCnt);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            // A push landing on the same edge as a flush is dropped.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pn_soma_controller.sv
// Configures one soma, then issues queued events to it one at a time under o_wait back-pressure.
// Forwards fired spikes upstream with a saturating count, and supports a config-preserving kill.
module pn_soma_controller
    import pn_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_data,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [15:0]      ev_interval,
    input  logic [15:0]      ev_weight,
    input  logic             kill_req,
    output logic             soma_rst_n,
    output logic             soma_en,
    output logic             soma_kill,
    output logic [31:0]      soma_wdata,
    output logic [15:0]      soma_weight,
    input  logic             soma_wait,
    input  logic [15:0]      soma_spike,
    output logic             spk_valid,
    output logic [15:0]      spk_time,
    output logic [CNT_W-1:0] spk_cnt,
    output logic             busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    state_e          state;
    logic [CfgW-1:0] cfg_reg;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EvW-1:0]  fifo_rdata;
    logic [AW:0]     fifo_count;
    logic            kill_ok;
    logic            soma_active;

    assign soma_active = (state == StIssue) || (state == StHold);
    assign kill_ok     = kill_req && ((state == StReady) || soma_active);

    assign fifo_flush = kill_ok;
    assign fifo_push  = ev_valid && !fifo_full;
    // Pops happen only on the edge that enters ISSUE; kill wins over issuing.
    assign fifo_pop   = !kill_ok && !fifo_empty &&
                        ((state == StReady) || ((state == StHold) && !soma_wait));

    pn_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EvW)
    ) u_event_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata ({ev_interval, ev_weight}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cfg_ready  = (state == StUncfg) || ((state == StReady) && fifo_empty);
    assign ev_ready   = !fifo_full;
    assign soma_rst_n = (state != StUncfg) && (state != StLoad);
    assign soma_en    = soma_active;
    assign busy       = (state == StLoad) || soma_active || (fifo_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StUncfg;
            cfg_reg     <= '0;
            soma_wdata  <= '0;
            soma_weight <= '0;
            soma_kill   <= 1'b0;
            spk_valid   <= 1'b0;
            spk_time    <= '0;
            spk_cnt     <= '0;
        end else begin
            soma_kill <= kill_ok;
            spk_valid <= 1'b0;

            if (soma_active && (soma_spike != '0)) begin
                spk_valid <= 1'b1;
                spk_time  <= soma_spike;
                if (spk_cnt != '1) spk_cnt <= spk_cnt + CNT_W'(1);
            end

            if (fifo_pop) begin
                soma_wdata  <= ev_wdata(fifo_rdata[EvW-1 -: EvIntW]);
                soma_weight <= fifo_rdata[EvWeightW-1:0];
            end

            if (kill_ok) begin
                state <= StReady;
            end else begin
                unique case (state)
                    StUncfg: begin
                        if (cfg_valid) begin
                            cfg_reg    <= cfg_data;
                            soma_wdata <= cfg_data;
                            state      <= StLoad;
                        end
                    end
                    StLoad: begin
                        soma_wdata <= cfg_reg;
                        spk_cnt    <= '0;
                        state      <= StReady;
                    end
                    StReady: begin
                        if (cfg_valid && fifo_empty) begin
                            cfg_reg    <= cfg_data;
                            soma_wdata <= cfg_data;
                            state      <= StLoad;
                        end else if (!fifo_empty) begin
                            state <= StIssue;
                        end
                    end
                    StIssue: state <= StHold;
                    StHold: begin
                        if (!soma_wait) state <= fifo_empty ? StReady : StIssue;
                    end
                    default: state <= StUncfg;
                endcase
            end
        end
    end

endmodule
